// File: rtl/ahb_slave_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_controller
//  Purpose  : Transfer sequencer for the AHB-Lite slave register/buffer
//             interface. Accepts address phases, registers the transfer
//             attributes for the address decoder, inserts wait states while
//             the data buffer cannot satisfy a buffer access, and issues the
//             two-cycle ERROR response for illegal accesses.
//  Ports    : clk, n_rst (async active-low)
//             hsel, htrans, haddr, hsize, hwrite    - AHB address phase
//             buffer_occupancy                      - bytes held in buffer
//             haddr_reg, hsize_reg, hwrite_reg,
//             hsel_reg                              - registered transfer
//             state                                 - 0 IDLE, 1 DATA,
//                                                     2 WAIT, 3 ERROR
//             hready, hresp                         - AHB response
//  Options  : `define WAIT_TIMEOUT_EN to error a buffer access that stays in
//             WAIT for WAIT_MAX cycles. Undefined (default): WAIT persists
//             until the buffer can satisfy the transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_controller #(
    parameter int BUF_DEPTH = 64,
    parameter int WAIT_MAX  = 15
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hsel,
    input  logic [1:0] htrans,
    input  logic [3:0] haddr,
    input  logic [1:0] hsize,
    input  logic       hwrite,
    input  logic [6:0] buffer_occupancy,
    output logic [3:0] haddr_reg,
    output logic [1:0] hsize_reg,
    output logic       hwrite_reg,
    output logic       hsel_reg,
    output logic [1:0] state,
    output logic       hready,
    output logic       hresp
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_WAIT = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    localparam logic [8:0] C_BUF_DEPTH = 9'(BUF_DEPTH);

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;
    logic   w_illegal;
    logic   w_buf_region;
    logic   w_buf_ok_new;
    logic   w_buf_ok_pend;

    // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    logic   w_unused_htrans0;
    assign w_unused_htrans0 = htrans[0];

`ifdef WAIT_TIMEOUT_EN
    localparam logic [7:0] C_WAIT_MAX = 8'(WAIT_MAX);
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
`else
    // Timeout removed in this build; WAIT_MAX has no effect.
    logic [7:0] w_unused_wait_max;
    assign w_unused_wait_max = 8'(WAIT_MAX);
`endif

    // Can the buffer move 2**size bytes in the requested direction right now?
    function automatic logic buf_ok(input logic [1:0] size, input logic write,
                                    input logic [6:0] occ);
        logic [8:0] need;
        logic [8:0] occ9;
        need = 9'd1 << size;
        occ9 = {2'b00, occ};
        if (write)
            buf_ok = (occ9 + need) <= C_BUF_DEPTH;
        else
            buf_ok = occ9 >= need;
    endfunction

    // Moore outputs
    assign hready   = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign hresp    = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign w_accept = hready && hsel && htrans[1];

    always_comb begin
        state = 2'd0;
        case (r_state)
            S_DATA:         state = 2'd1;
            S_WAIT:         state = 2'd2;
            S_ERR1, S_ERR2: state = 2'd3;
            default:        state = 2'd0;
        endcase
    end

    assign w_buf_region  = (haddr[3:2] == 2'b00);
    assign w_buf_ok_new  = buf_ok(hsize, hwrite, buffer_occupancy);
    // While waiting, the stalled transfer is the registered one.
    assign w_buf_ok_pend = buf_ok(hsize_reg, hwrite_reg, buffer_occupancy);

    // Illegal access classification of the incoming address phase. Word
    // accesses inside the buffer region are not alignment-checked.
    always_comb begin
        w_illegal = 1'b0;
        if (hsize == 2'd3)
            w_illegal = 1'b1;
        else if ((haddr >= 4'h9 && haddr <= 4'hB) || haddr >= 4'hE)
            w_illegal = 1'b1;
        else if ((hsize == 2'd1 && haddr[0]) ||
                 (hsize == 2'd2 && haddr[1:0] != 2'b00 && haddr[3:2] != 2'b00))
            w_illegal = 1'b1;
        else if (hwrite && haddr >= 4'h4 && haddr <= 4'h8)
            w_illegal = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
`ifdef WAIT_TIMEOUT_EN
        w_wait_cnt_next = r_wait_cnt;
`endif
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (!w_accept) begin
                    w_state_next = S_IDLE;
                end else if (w_illegal) begin
                    w_state_next = S_ERR1;
                end else if (w_buf_region && !w_buf_ok_new) begin
                    w_state_next = S_WAIT;
`ifdef WAIT_TIMEOUT_EN
                    w_wait_cnt_next = 8'd0;
`endif
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_WAIT: begin
                // A satisfied buffer wins over a timeout in the same cycle.
                if (w_buf_ok_pend) begin
                    w_state_next = S_DATA;
                end else begin
`ifdef WAIT_TIMEOUT_EN
                    if (r_wait_cnt < C_WAIT_MAX)
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    if (w_wait_cnt_next >= C_WAIT_MAX)
                        w_state_next = S_ERR1;
`else
                    w_state_next = S_WAIT;
`endif
                end
            end
            S_ERR1:  w_state_next = S_ERR2;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            haddr_reg  <= 4'd0;
            hsize_reg  <= 2'd0;
            hwrite_reg <= 1'b0;
            hsel_reg   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                haddr_reg  <= haddr;
                hsize_reg  <= hsize;
                hwrite_reg <= hwrite;
                hsel_reg   <= hsel;
            end else if (hready) begin
                // Idle slot: attributes hold, select no longer qualified.
                hsel_reg <= 1'b0;
            end
        end
    end

`ifdef WAIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_wait_cnt <= 8'd0;
        else
            r_wait_cnt <= w_wait_cnt_next;
    end
`endif

endmodule
`default_nettype wire
